// File: rtl/cw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cw_pkg
// Description : Shared types and constants for the constant-weight word
//               serializer: FSM state encoding, default code-set geometry
//               and a ceiling-log2 helper for sizing counters.
// Revision    : 1.0 - initial release
// ============================================================================
package cw_pkg;

  // Control FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } cw_state_e;

  // Default geometry of the 10-bit / 38-word code set
  localparam int C_CW10_WORD_W = 10;
  localparam int C_CW10_DEPTH  = 38;

  // Ceiling log2; returns 0 for values of 0 or 1
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cw_bit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : cw_bit_shifter
// Description : Loads one word plus its significant length, then presents its
//               bits one at a time under a valid/ready handshake, LSB first or
//               MSB first. Holds the current bit while the consumer stalls and
//               flags the acceptance of the final bit of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module cw_bit_shifter #(
  parameter int WORD_W    = 10,
  parameter int LEN_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              bit_rdy,
  output logic              bit_out,
  output logic              bit_vld,
  output logic              word_last
);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;

  logic [WORD_W-1:0] w_load_img;
  logic [WORD_W-1:0] w_shifted;
  logic              w_accept;

  assign w_accept  = vld_q & bit_rdy;
  assign word_last = w_accept && (cnt_q == LEN_W'(1));
  assign bit_vld   = vld_q;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      // Left-align the significant bits so the next bit always sits at the top
      localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(WORD_W);
      logic [LEN_W-1:0] w_pad;
      assign w_pad      = C_MAX_LEN - load_len;
      assign w_load_img = load_data << w_pad;
      assign w_shifted  = sreg_q << 1;
      assign bit_out    = sreg_q[WORD_W-1];
    end else begin : g_lsb
      assign w_load_img = load_data;
      assign w_shifted  = sreg_q >> 1;
      assign bit_out    = sreg_q[0];
    end
  endgenerate

  // Next-state: load a fresh word, or advance one bit on an accepted handshake
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (load) begin
      sreg_d = w_load_img;
      cnt_d  = load_len;
      vld_d  = (load_len != '0);
    end else if (w_accept) begin
      sreg_d = w_shifted;
      cnt_d  = cnt_q - LEN_W'(1);
      if (cnt_q == LEN_W'(1)) begin
        vld_d = 1'b0;
      end
    end
  end

  // Shift register, bit counter and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cw_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cw_word_serializer
// Description : Buffers up to DEPTH words, each with its own significant bit
//               length, and on start streams the concatenated significant
//               bits out through a valid/ready handshake, pulsing msg_done
//               once the last bit has been accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module cw_word_serializer
  import cw_pkg::*;
#(
  parameter int WORD_W    = C_CW10_WORD_W,
  parameter int DEPTH     = C_CW10_DEPTH,
  parameter int LEN_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic [LEN_W-1:0]          wr_len,
  input  logic                      start,
  output logic                      bit_out,
  output logic                      bit_vld,
  input  logic                      bit_rdy,
  output logic                      busy,
  output logic                      full,
  output logic [clog2(DEPTH+1)-1:0] word_cnt,
  output logic                      msg_done,
  output logic                      wr_err
);

  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(WORD_W);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);

  cw_state_e         state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic              wr_err_q, wr_err_d;
  logic              start_pend_q, start_pend_d;

  logic [WORD_W-1:0] data_mem_q [DEPTH];
  logic [LEN_W-1:0]  len_mem_q  [DEPTH];

  logic              w_wr_commit;
  logic              w_shift_load;
  logic              w_word_last;
  logic              w_last_word;
  logic [LEN_W-1:0]  w_len_clamped;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [WORD_W-1:0] w_rd_data;
  logic [LEN_W-1:0]  w_rd_len;

  assign w_len_clamped = (wr_len > C_MAX_LEN) ? C_MAX_LEN : wr_len;
  assign w_wr_idx      = word_cnt_q[IDX_W-1:0];
  assign w_rd_idx      = rd_idx_q[IDX_W-1:0];
  assign w_rd_data     = data_mem_q[w_rd_idx];
  assign w_rd_len      = len_mem_q[w_rd_idx];
  assign w_last_word   = (rd_idx_q == (word_cnt_q - CNT_W'(1)));

  assign busy     = (state_q != ST_IDLE);
  assign full     = (word_cnt_q == C_DEPTH);
  assign word_cnt = word_cnt_q;
  assign msg_done = (state_q == ST_DONE);
  assign wr_err   = wr_err_q;

  // Write acceptance, control FSM transitions and read-index sequencing
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    rd_idx_d     = rd_idx_q;
    wr_err_d     = wr_err_q;
    start_pend_d = 1'b0;
    w_wr_commit  = 1'b0;
    w_shift_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          // A start arriving with a write waits a cycle to see the new count
          start_pend_d = start | start_pend_q;
          if (full) begin
            wr_err_d = 1'b1;
          end else begin
            w_wr_commit = 1'b1;
            word_cnt_d  = word_cnt_q + CNT_W'(1);
          end
        end else if (start | start_pend_q) begin
          rd_idx_d = '0;
          state_d  = (word_cnt_q == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_rd_len == '0) begin
          if (w_last_word) begin
            state_d = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
          end
        end else begin
          w_shift_load = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_word_last) begin
          if (w_last_word) begin
            state_d = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Any write while a message is in flight is dropped and remembered
    if (wr_en && (state_q != ST_IDLE)) begin
      wr_err_d = 1'b1;
    end
  end

  // Control state, counters and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      rd_idx_q     <= '0;
      wr_err_q     <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      rd_idx_q     <= rd_idx_d;
      wr_err_q     <= wr_err_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Word buffer: contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      data_mem_q[w_wr_idx] <= wr_data;
      len_mem_q[w_wr_idx]  <= w_len_clamped;
    end
  end

  cw_bit_shifter #(
    .WORD_W    (WORD_W),
    .LEN_W     (LEN_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (w_shift_load),
    .load_data (w_rd_data),
    .load_len  (w_rd_len),
    .bit_rdy   (bit_rdy),
    .bit_out   (bit_out),
    .bit_vld   (bit_vld),
    .word_last (w_word_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_cw_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cw_word_serializer
// Description : Self-checking bench for cw_word_serializer (LSB-first default
//               instance plus an MSB-first instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cw_word_serializer;

  localparam int WORD_W = 10;
  localparam int DEPTH  = 38;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LSB-first instance signals
  logic              wr_en   = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic [LEN_W-1:0]  wr_len  = '0;
  logic              start   = 1'b0;
  logic              bit_rdy = 1'b1;
  logic              bit_out, bit_vld, busy, full, msg_done, wr_err;
  logic [CNT_W-1:0]  word_cnt;

  // MSB-first instance signals
  logic              m_wr_en   = 1'b0;
  logic [WORD_W-1:0] m_wr_data = '0;
  logic [LEN_W-1:0]  m_wr_len  = '0;
  logic              m_start   = 1'b0;
  logic              m_bit_rdy = 1'b1;
  logic              m_bit_out, m_bit_vld, m_busy, m_full, m_msg_done, m_wr_err;
  logic [CNT_W-1:0]  m_word_cnt;

  cw_word_serializer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_len(wr_len),
    .start(start), .bit_out(bit_out), .bit_vld(bit_vld), .bit_rdy(bit_rdy),
    .busy(busy), .full(full), .word_cnt(word_cnt), .msg_done(msg_done),
    .wr_err(wr_err)
  );

  cw_word_serializer #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .wr_en(m_wr_en), .wr_data(m_wr_data), .wr_len(m_wr_len),
    .start(m_start), .bit_out(m_bit_out), .bit_vld(m_bit_vld), .bit_rdy(m_bit_rdy),
    .busy(m_busy), .full(m_full), .word_cnt(m_word_cnt), .msg_done(m_msg_done),
    .wr_err(m_wr_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [WORD_W-1:0] d;
    int                l;
  } word_t;

  word_t mdl_words[$];
  bit    mdl_exp[$];
  bit    cap[$];
  bit    mq[$];
  int    mdl_cnt  = 0;
  bit    mdl_err  = 1'b0;
  bit    mdl_busy = 1'b0;

  function automatic int clamp_len(input int l);
    return (l > WORD_W) ? WORD_W : l;
  endfunction

  // Bit i of a word's emitted sequence
  function automatic bit bit_of(input logic [WORD_W-1:0] d, input int l, input int i, input bit msb);
    int lc;
    lc = clamp_len(l);
    return msb ? d[lc-1-i] : d[i];
  endfunction

  function automatic void model_write(input logic [WORD_W-1:0] d, input int l);
    word_t w;
    if (!mdl_busy && mdl_cnt < DEPTH) begin
      w.d = d;
      w.l = l;
      mdl_words.push_back(w);
      mdl_cnt++;
    end else begin
      mdl_err = 1'b1;
    end
  endfunction

  function automatic void model_start();
    foreach (mdl_words[k]) begin
      for (int i = 0; i < clamp_len(mdl_words[k].l); i++) begin
        mdl_exp.push_back(bit_of(mdl_words[k].d, mdl_words[k].l, i, 1'b0));
      end
    end
    mdl_words.delete();
    mdl_busy = 1'b1;
  endfunction

  function automatic void model_reset();
    mdl_words.delete();
    mdl_exp.delete();
    mdl_cnt  = 0;
    mdl_err  = 1'b0;
    mdl_busy = 1'b0;
  endfunction

  // ---------------- compare process ----------------
  int cyc = 0;
  int last_acc = 0;
  int msg_acc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int m_done_cnt = 0;
  bit prev_vld = 1'b0;
  bit prev_rdy = 1'b0;
  bit prev_bit = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk_eq("hold_vld", bit_vld, 1);
        chk_eq("hold_bit", bit_out, prev_bit);
      end
      if (bit_vld) begin
        chk_eq("vld_in_msg", mdl_busy, 1);
        if (bit_rdy && mdl_busy) begin
          acc_cnt++;
          msg_acc++;
          last_acc = cyc;
          cap.push_back(bit_out);
          chk_eq("bits_remaining", (mdl_exp.size() > 0), 1);
          if (mdl_exp.size() > 0) begin
            chk_eq("stream_bit", bit_out, mdl_exp.pop_front());
          end
        end
      end
      if (msg_done) begin
        chk_eq("done_expected", mdl_busy, 1);
        chk_eq("done_bits_left", mdl_exp.size(), 0);
        if (msg_acc > 0) begin
          chk_eq("done_latency", cyc - last_acc, 1);
        end
        msg_acc  = 0;
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
        done_cnt++;
      end else if (!mdl_busy) begin
        chk_eq("idle_word_cnt", word_cnt, mdl_cnt);
        chk_eq("idle_full", full, (mdl_cnt == DEPTH));
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_wr_err", wr_err, mdl_err);
      end
      prev_vld = bit_vld;
      prev_rdy = bit_rdy;
      prev_bit = bit_out;
    end
  end

  // Capture of the MSB-first instance's accepted bits
  always @(negedge clk) begin
    if (!rst) begin
      if (m_bit_vld && m_bit_rdy) mq.push_back(m_bit_out);
      if (m_msg_done) m_done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WORD_W-1:0] d, input int l);
    wr_en   = 1'b1;
    wr_data = d;
    wr_len  = LEN_W'(l);
    tick();
    wr_en = 1'b0;
    model_write(d, l);
  endtask

  // mode 1: check start-to-first-bit latency; mode 2: empty-buffer message
  task automatic run_msg(input bit bp, input int wr_at, input int mode);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      if (mode == 1 && c == 0) chk_eq("lat_load_vld", bit_vld, 0);
      if (mode == 1 && c == 1) chk_eq("lat_first_vld", bit_vld, 1);
      if (mode == 2 && c == 0) begin
        chk_eq("empty_done", msg_done, 1);
        chk_eq("empty_vld", bit_vld, 0);
      end
      bit_rdy = bp ? (((c % 4) == 0) || ((c % 4) == 3)) : 1'b1;
      if (c == wr_at) begin
        wr_en   = 1'b1;
        wr_data = 10'h155;
        wr_len  = 4'd5;
      end
      tick();
      if (c == wr_at) begin
        wr_en = 1'b0;
        model_write(10'h155, 5);
      end
    end
    chk_eq("msg_done_seen", done_cnt - d0, 1);
    bit_rdy = 1'b1;
  endtask

  task automatic cmp_cap(input string name, input int n, input logic [31:0] pat);
    logic [31:0] got;
    got = '0;
    chk_eq({name, "_len"}, cap.size(), n);
    foreach (cap[i]) if (i < 32) got[i] = cap[i];
    chk_eq(name, got, pat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0;
    int mism;
    logic [31:0] mpk;

    model_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk_eq("rst_bit_out", bit_out, 0);
    chk_eq("rst_bit_vld", bit_vld, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_full", full, 0);
    chk_eq("rst_word_cnt", word_cnt, 0);
    chk_eq("rst_msg_done", msg_done, 0);
    chk_eq("rst_wr_err", wr_err, 0);

    // MSB-first instance: 11/4 then 5/3
    m_wr_en = 1'b1; m_wr_data = 10'd11; m_wr_len = 4'd4;
    tick();
    m_wr_data = 10'd5; m_wr_len = 4'd3;
    tick();
    m_wr_en = 1'b0;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int c = 0; c < 50 && m_done_cnt == 0; c++) tick();
    chk_eq("msb_done", m_done_cnt, 1);
    chk_eq("msb_len", mq.size(), 7);
    mism = 0;
    mpk  = '0;
    foreach (mq[i]) begin
      if (i < 32) mpk[i] = mq[i];
      if (i < 4) begin
        if (mq[i] != bit_of(10'd11, 4, i, 1'b1)) mism++;
      end else if (i < 7) begin
        if (mq[i] != bit_of(10'd5, 3, i - 4, 1'b1)) mism++;
      end
    end
    chk_eq("msb_vs_model", mism, 0);
    chk_eq("msb_stream", mpk, 32'h5D);

    // Basic LSB-first: 2/3, 0/2, 6/4 -> 0,1,0,0,0,0,1,1,0
    wr(10'd2, 3);
    wr(10'd0, 2);
    wr(10'd6, 4);
    chk_eq("basic_cnt", word_cnt, 3);
    cap.delete();
    run_msg(1'b0, -1, 1);
    cmp_cap("basic_stream", 9, 32'h0C2);
    tick();
    chk_eq("basic_cnt_clr", word_cnt, 0);

    // Backpressure: 6/4 -> 0,1,1,0 with rdy 1,0,0,1,...
    wr(10'd6, 4);
    cap.delete();
    a0 = acc_cnt;
    run_msg(1'b1, -1, 0);
    chk_eq("bp_accepts", acc_cnt - a0, 4);
    cmp_cap("bp_stream", 4, 32'h6);

    // Fill to DEPTH, overflow, then a write while shifting
    for (int i = 0; i < DEPTH; i++) wr(WORD_W'(i * 37), i % 12);
    chk_eq("fill_full", full, 1);
    chk_eq("fill_cnt", word_cnt, DEPTH);
    chk_eq("fill_no_err", wr_err, 0);
    wr(10'h3FF, 3);
    chk_eq("ovf_err", wr_err, 1);
    chk_eq("ovf_cnt", word_cnt, DEPTH);
    run_msg(1'b0, 5, 0);
    tick();
    chk_eq("busy_wr_err", wr_err, 1);

    // Empty buffer start
    run_msg(1'b0, -1, 2);

    // Zero-length skip and clamp of length 15 -> 10 ones, then 1 one
    wr(10'd5, 0);
    wr(10'h3FF, 15);
    wr(10'd1, 1);
    cap.delete();
    run_msg(1'b0, -1, 0);
    cmp_cap("clamp_stream", 11, 32'h7FF);

    // Reset after 5 accepted bits
    wr(10'h2D5, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    a0 = acc_cnt;
    for (int c = 0; c < 100 && (acc_cnt - a0) < 5; c++) tick();
    chk_eq("mid_accepts", acc_cnt - a0, 5);
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    chk_eq("mid_bit_out", bit_out, 0);
    chk_eq("mid_bit_vld", bit_vld, 0);
    chk_eq("mid_busy", busy, 0);
    chk_eq("mid_word_cnt", word_cnt, 0);
    chk_eq("mid_msg_done", msg_done, 0);
    chk_eq("mid_wr_err", wr_err, 0);
    chk_eq("mid_full", full, 0);
    a0 = done_cnt;
    for (int c = 0; c < 5; c++) tick();
    chk_eq("mid_no_done", done_cnt - a0, 0);

    // Fresh message after the abort: 2/3, 6/4 -> 0,1,0,0,1,1,0
    wr(10'd2, 3);
    wr(10'd6, 4);
    cap.delete();
    run_msg(1'b0, -1, 1);
    cmp_cap("fresh_stream", 7, 32'h32);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time bound
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cw_word_serializer.md
Name: cw_word_serializer

Overview:
- Parametrised successor to the constant-weight decoder input stage.
- Buffers up to DEPTH codeword fields of WORD_W bits, each written with its own significant bit length.
- On start, emits the concatenated significant bits as a serial binary message under a valid/ready handshake, then pulses msg_done.
- Sits between the host word-write interface and the bit-serial constant-weight decode datapath.

Parameters:
- WORD_W, 10, width of each stored word
- DEPTH, 38, maximum words per message
- LEN_W, 4, width of per-word length field; must satisfy 2^LEN_W > WORD_W
- MSB_FIRST, 0, 0 = emit each word LSB first; 1 = emit from bit len-1 down to bit 0

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe for one word
- wr_data  in  WORD_W  word value
- wr_len  in  LEN_W  number of significant bits in wr_data
- start  in  1  one-cycle pulse that begins serialisation
- bit_out  out  1  current message bit
- bit_vld  out  1  bit_out is valid
- bit_rdy  in  1  consumer accepts bit_out this cycle
- busy  out  1  high outside IDLE
- full  out  1  word count equals DEPTH
- word_cnt  out  $clog2(DEPTH+1)  number of words stored
- msg_done  out  1  one-cycle pulse after the last bit is accepted
- wr_err  out  1  sticky: a write was dropped

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: bit_out=0, bit_vld=0, busy=0, full=0, word_cnt=0, msg_done=0, wr_err=0. Buffer contents are don't-care. State = IDLE.
- Storage is a DEPTH x (WORD_W+LEN_W) register array, written at index word_cnt.
- Write rules:
  - wr_en in IDLE with !full: store the word, word_cnt+1 on the next edge.
  - wr_en while full or busy: the word is dropped and wr_err=1. wr_err clears only on rst.
- Length rule: wr_len > WORD_W is clamped to WORD_W at write time.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start with word_cnt>0 -> LOAD; rd_idx=0.
  - start with word_cnt=0 -> DONE directly.
  - wr_en and start in the same cycle: the write is committed first. start then sees the updated count on the next edge, so it is deferred one cycle.
- LOAD:
  - Fetch word[rd_idx] into a shift register; bit counter = len.
  - If len=0, skip the word: rd_idx+1, stay in LOAD, or go to DONE if it was the last word.
  - Otherwise -> SHIFT; bit_vld asserted from the next cycle.
- SHIFT:
  - bit_vld=1 and bit_out = current bit, per MSB_FIRST.
  - bit_out and bit_vld are held stable while bit_rdy=0.
  - On bit_vld&&bit_rdy: advance the shift register and decrement the counter.
  - Last bit of a word accepted -> LOAD next word (one bubble cycle, bit_vld=0), or DONE if rd_idx=word_cnt-1.
- DONE:
  - msg_done=1 for exactly one cycle; word_cnt cleared to 0; full=0.
  - Next state IDLE.
- start outside IDLE is ignored.
- Total bits emitted equal the sum of the clamped lengths. Bit latency from start to first bit_vld is 2 cycles when word 0 has len>0.
- rst in any state aborts immediately. No msg_done is generated for an aborted message.
- full is combinational from word_cnt==DEPTH.

Decomposition:
- Shared package cw_pkg holds:
  - state encoding (IDLE/LOAD/SHIFT/DONE)
  - default WORD_W/DEPTH constants per code set (10/38)
  - a function clog2
- One natural sub-module: cw_bit_shifter. It covers load, the MSB/LSB-first shift register, the bit counter and the handshake hold.
- The word buffer and the control FSM stay in the top.

Test Plan:
- Basic LSB-first: write words 2,0,6 with lengths 3,2,4; start; bit_rdy=1. Required stream: 0,1,0, 0,0, 0,1,1,0. Then msg_done one cycle after the last accept; word_cnt=0.
- MSB_FIRST=1 instance: write 11 with length 4, then 5 with length 3. Required stream: 1,0,1,1, 1,0,1.
- Backpressure: word 6, length 4; bit_rdy toggles 1,0,0,1,... Each bit_out is held across stall cycles, no bit is lost or duplicated, and exactly 4 accepts occur.
- Full/overflow: 38 writes -> full=1 and word_cnt=38. A 39th write is dropped and wr_err=1. Writes during SHIFT are also dropped.
- Edge cases:
  - start with empty buffer -> msg_done 1 cycle later, no bit_vld.
  - A word with length 0 is skipped.
  - wr_len=15 is clamped to 10 bits.
- Reset mid-SHIFT: rst after 5 bits -> all outputs reach reset values on the next edge, no msg_done. A fresh message afterwards serialises correctly.
